score_display_mux: RTL and testbench

//  Downstream consumer of the cascaded bcd_counter score digits in PONG.

---
 rtl/score_display_mux_pkg.sv | 19 +
 rtl/score_display_mux_bcd_to_7seg.sv | 27 ++
 rtl/score_display_mux.sv | 90 +++++++++
 tb/tb_score_display_mux.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/score_display_mux_pkg.sv
// Shared constants for the score display: active-low 7-segment patterns {g,f,e,d,c,b,a}.
// Used by the decoder and by the blanking logic in the top.
package score_display_mux_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/score_display_mux_bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_7seg
   import score_display_mux_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      // NOTE: default assignment first so no path through the case can infer a latch.
      seg = SEG_DASH;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/score_display_mux.sv
// Time-multiplexed common-anode score display with per-frame digit latching and
// anode blanking at slot start. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module score_display_mux
   import score_display_mux_pkg::*;
#(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 12,
   parameter int BLANK_CYC = 4
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  en,
   input  logic [4*DIGITS-1:0]   digits_bcd,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_tick
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [SCAN_DIV-1:0] p;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] shadow;

   logic                p_max;
   logic                idx_last;
   logic                lit;
   logic                blank_digit;
   logic [3:0]          cur_digit;
   logic [6:0]          dec_seg;
   logic [DIGITS-1:0]   an_next;

   assign p_max     = &p;
   assign idx_last  = (idx == IW'(DIGITS - 1));
   assign lit       = (p >= SCAN_DIV'(BLANK_CYC));
   assign cur_digit = shadow[4*int'(idx) +: 4];

   bcd_to_7seg u_dec (
      .bcd (cur_digit),
      .seg (dec_seg)
   );

`ifdef LEADING_ZERO_BLANK_EN
   // lz[k] is set when digit k and every digit above it are zero.
   logic [DIGITS-1:0] lz;
   always_comb begin
      lz = '0;
      lz[DIGITS-1] = (shadow[4*DIGITS-1 -: 4] == 4'd0);
      for (int k = DIGITS - 2; k >= 0; k--) begin
         lz[k] = lz[k+1] && (shadow[4*k +: 4] == 4'd0);
      end
   end
   assign blank_digit = (idx != '0) && lz[idx];
`else
   assign blank_digit = 1'b0;
`endif

   always_comb begin
      an_next = '1;
      if (lit) an_next[idx] = 1'b0;
   end

   // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (clr) begin
         p          <= '0;
         idx        <= '0;
         shadow     <= '0;
         seg        <= SEG_BLANK;
         an         <= '1;
         frame_tick <= 1'b0;
      end else if (en) begin
         p          <= p + 1'b1;
         frame_tick <= p_max && idx_last;
         if (p_max) begin
            if (idx_last) begin
               idx    <= '0;
               shadow <= digits_bcd;
            end else begin
               idx    <= idx + 1'b1;
            end
         end
         an  <= an_next;
         seg <= (lit && !blank_digit) ? dec_seg : SEG_BLANK;
      end else begin
         frame_tick <= 1'b0;
      end
   end

endmodule

// File: tb/tb_score_display_mux.sv
// Self-checking bench for score_display_mux (DIGITS=4, SCAN_DIV=3, BLANK_CYC=1):
// cycle model feeds a scoreboard queue, plus directed slot checks.
module tb_score_display_mux;

   localparam int DIGITS    = 4;
   localparam int SCAN_DIV  = 3;
   localparam int BLANK_CYC = 1;
   localparam int SLOT      = 1 << SCAN_DIV;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       ft;
   } exp_t;

   logic        clk = 1'b0;
   logic        clr;
   logic        en;
   logic [15:0] digits_bcd;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_tick;

   int total = 0;
   int bad   = 0;

   exp_t sb_q[$];

   int          m_p   = 0;
   int          m_idx = 0;
   logic [15:0] m_sh  = '0;
   logic [3:0]  m_an  = 4'hF;
   logic [6:0]  m_seg = 7'h7F;

   logic [6:0] dec_tab [16];

   score_display_mux #(
      .DIGITS    (DIGITS),
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .en         (en),
      .digits_bcd (digits_bcd),
      .seg        (seg),
      .an         (an),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] model_seg(input logic [15:0] sh, input int k);
      logic [15:0] upper;
      upper = sh >> (4 * k);
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && upper == 16'h0) return 7'h7F;
`endif
      return dec_tab[upper[3:0]];
   endfunction

   // One clock: predict the registered outputs, push them, advance, pop and compare.
   task automatic step();
      exp_t e;
      exp_t got;
      if (clr) begin
         e = '{an: 4'hF, seg: 7'h7F, ft: 1'b0};
         m_p = 0; m_idx = 0; m_sh = '0;
      end else if (!en) begin
         e = '{an: m_an, seg: m_seg, ft: 1'b0};
      end else begin
         e.an  = 4'hF;
         e.seg = 7'h7F;
         if (m_p >= BLANK_CYC) begin
            e.an[m_idx] = 1'b0;
            e.seg = model_seg(m_sh, m_idx);
         end
         e.ft = (m_p == SLOT - 1) && (m_idx == DIGITS - 1);
         if (m_p == SLOT - 1) begin
            if (m_idx == DIGITS - 1) begin
               m_idx = 0;
               m_sh  = digits_bcd;
            end else begin
               m_idx++;
            end
         end
         m_p = (m_p + 1) % SLOT;
      end
      m_an  = e.an;
      m_seg = e.seg;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = '{an: an, seg: seg, ft: frame_tick};
      e = sb_q.pop_front();
      check("scoreboard {an,seg,ft}", 32'(got), 32'(e));
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_to_frame_start();
      int guard;
      guard = 0;
      while (!(m_p == 0 && m_idx == 0) && guard < 64) begin
         step();
         guard++;
      end
      check("frame_align", 32'(m_p == 0 && m_idx == 0), 32'd1);
   endtask

   // Blank clock at slot start, then the lit digit, then the rest of the slot.
   task automatic check_slot(input string tag, input logic [3:0] an_exp, input logic [6:0] seg_exp);
      step();
      check({tag, " an_blank"}, 32'(an), 32'hF);
      step();
      check({tag, " an"}, 32'(an), 32'(an_exp));
      check({tag, " seg"}, 32'(seg), 32'(seg_exp));
      run_n(SLOT - 2);
   endtask

   initial begin
      logic [6:0] seg_a [4];
      logic [6:0] seg_b [4];
      logic [6:0] seg_c [4];
      logic [6:0] seg_d [4];
      logic [6:0] lz_seg;
      logic [3:0] held_an;
      logic [6:0] held_seg;
      int tick_at;

      dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
      seg_a = '{7'h19, 7'h30, 7'h24, 7'h79};
      seg_b = '{7'h00, 7'h78, 7'h02, 7'h12};
      seg_c = '{7'h3F, 7'h40, 7'h3F, 7'h10};
`ifdef LEADING_ZERO_BLANK_EN
      lz_seg = 7'h7F;
`else
      lz_seg = 7'h40;
`endif
      seg_d = '{7'h78, lz_seg, lz_seg, lz_seg};

      clr = 1'b1;
      en  = 1'b1;
      digits_bcd = 16'h1234;

      // 1. reset, then first frame tick 32 clocks after release
      run_n(2);
      check("reset an", 32'(an), 32'hF);
      check("reset seg", 32'(seg), 32'h7F);
      check("reset frame_tick", 32'(frame_tick), 32'd0);
      clr = 1'b0;
      tick_at = -1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (frame_tick === 1'b1) begin
            tick_at = i;
            break;
         end
      end
      check("first frame_tick clk", 32'(tick_at), 32'd32);

      // 2. 16'h1234 shown digit 0 first
      for (int s = 0; s < 4; s++)
         check_slot($sformatf("f1234 slot%0d", s), ~(4'b0001 << s), seg_a[s]);

      // 3. change mid-frame: remaining slots keep old digits
      check_slot("mid slot0", 4'hE, seg_a[0]);
      digits_bcd = 16'h5678;
      for (int s = 1; s < 4; s++)
         check_slot($sformatf("mid slot%0d", s), ~(4'b0001 << s), seg_a[s]);
      for (int s = 0; s < 4; s++)
         check_slot($sformatf("f5678 slot%0d", s), ~(4'b0001 << s), seg_b[s]);

      // 4. non-BCD codes show dashes
      digits_bcd = 16'h9A0F;
      run_n(4 * SLOT);
      for (int s = 0; s < 4; s++)
         check_slot($sformatf("f9A0F slot%0d", s), ~(4'b0001 << s), seg_c[s]);

      // 5. freeze mid-slot for 20 clocks, then resume the same slot
      run_n(3);
      en = 1'b0;
      held_an  = an;
      held_seg = seg;
      for (int i = 0; i < 20; i++) begin
         step();
         check("hold {an,seg,ft}", {an, seg, frame_tick}, {held_an, held_seg, 1'b0});
      end
      en = 1'b1;
      run_n(SLOT - 3);
      check("resume an", 32'(an), 32'hE);
      check("resume seg", 32'(seg), 32'h3F);
      step();
      check("resume next blank", 32'(an), 32'hF);
      step();
      check("resume next an", 32'(an), 32'hD);
      run_to_frame_start();

      // 6. leading zeros, then clr in the middle of slot 2
      digits_bcd = 16'h0007;
      run_n(1);
      run_to_frame_start();
      for (int s = 0; s < 4; s++)
         check_slot($sformatf("f0007 slot%0d", s), ~(4'b0001 << s), seg_d[s]);
      check_slot("clr slot0", 4'hE, seg_d[0]);
      check_slot("clr slot1", 4'hD, seg_d[1]);
      run_n(4);
      check("pre-clr an", 32'(an), 32'hB);
      clr = 1'b1;
      step();
      check("clr an", 32'(an), 32'hF);
      check("clr seg", 32'(seg), 32'h7F);
      clr = 1'b0;
      step();
      check("post-clr blank", 32'(an), 32'hF);
      step();
      check("post-clr an idx0", 32'(an), 32'hE);
      check("post-clr seg zero", 32'(seg), 32'h40);
      check("scoreboard drained", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
